// File: rtl/digit_scan_mux_if.sv
// Interface for the digit scan controller: digit load bus and display-side outputs.
// The blink_mask signal exists only when BLINK_EN is defined.
interface digit_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    blank_lz_en;
`ifdef BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic [3:0]              code_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output digits_in, load, blank_lz_en,
`ifdef BLINK_EN
    output blink_mask,
`endif
    input  code_out, digit_sel, frame_done, pending
  );

  modport slave (
    input  digits_in, load, blank_lz_en,
`ifdef BLINK_EN
    input  blink_mask,
`endif
    output code_out, digit_sel, frame_done, pending
  );
endinterface

// File: rtl/digit_scan_mux.sv
// Multiplexed 7-segment scan controller with double-buffered digit codes and
// leading-zero blanking. Optional digit blinking is enabled by defining BLINK_EN.
module digit_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  digit_scan_mux_if.slave   bus
);
  localparam int          PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int          IW    = $clog2(NUM_DIGITS);
  localparam logic [3:0]  BLANK = 4'd14;

  if (NUM_DIGITS < 2 || PRESCALE < 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("digit_scan_mux: invalid parameter value");
  end

  logic [PW-1:0]                r_presc;
  logic [IW-1:0]                r_idx;
  logic                         r_frame_done;
  logic                         r_pending;
  logic [NUM_DIGITS-1:0][3:0]   r_active;
  logic [NUM_DIGITS-1:0][3:0]   r_pend_buf;

  logic                         w_tick;
  logic                         w_wrap;
  logic                         w_run;
  logic [NUM_DIGITS-1:0]        w_lz;
  logic [3:0]                   w_raw;
  logic [3:0]                   w_code_lz;
  logic [3:0]                   w_code;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap = w_tick && (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
    end
  end

  // A load on the commit edge is captured but does not take part in that commit;
  // it stays pending and is committed at the next frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_buf <= {NUM_DIGITS{BLANK}};
      r_active   <= {NUM_DIGITS{BLANK}};
      r_pending  <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_active <= r_pend_buf;
      end
      if (bus.load) begin
        r_pend_buf <= bus.digits_in;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // w_lz[i] is set when digit i and every more significant digit are zero.
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run   = w_run & (r_active[i] == 4'd0);
      w_lz[i] = w_run;
    end
  end

  assign w_raw     = r_active[r_idx];
  assign w_code_lz = (bus.blank_lz_en && w_lz[r_idx]) ? BLANK : w_raw;

`ifdef BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_wrap) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt  <= r_bcnt + 1'b1;
      end
    end
  end

  assign w_code = (!r_phase && bus.blink_mask[r_idx]) ? BLANK : w_code_lz;
`else
  assign w_code = w_code_lz;
`endif

  assign bus.code_out   = w_code;
  assign bus.digit_sel  = NUM_DIGITS'(1) << r_idx;
  assign bus.frame_done = r_frame_done;
  assign bus.pending    = r_pending;
endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomised and directed checks of digit_scan_mux against a cycle-count based model.
module tb_digit_scan_mux;
  localparam int ND = 4;
  localparam int PS = 3;
  localparam int BF = 2;
  localparam int FRAME = ND * PS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  digit_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // model state: edges since reset, displayed and pending digit values
  int m_n;
  int m_act[ND];
  int m_pbuf[ND];
  bit m_pend;
  bit m_fd;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_pend = 0;
    m_fd = 0;
    for (int i = 0; i < ND; i++) begin
      m_act[i] = 14;
      m_pbuf[i] = 14;
    end
  endtask

  task automatic model_edge();
    bit wrap;
    m_n++;
    wrap = (m_n % FRAME) == 0;
    if (wrap && m_pend) begin
      m_act = m_pbuf;
      m_pend = 0;
    end
    if (bus.load) begin
      for (int i = 0; i < ND; i++) m_pbuf[i] = int'(bus.digits_in[4*i +: 4]);
      m_pend = 1;
    end
    m_fd = wrap;
  endtask

  function automatic int exp_code(input int idx);
    int c;
    bit allz;
    c = m_act[idx];
    allz = 1;
    for (int j = idx; j < ND; j++) if (m_act[j] != 0) allz = 0;
    if (bus.blank_lz_en && idx > 0 && allz) c = 14;
`ifdef BLINK_EN
    if (((m_n / FRAME) / BF) % 2 == 1 && bus.blink_mask[idx]) c = 14;
`endif
    return c;
  endfunction

  task automatic check_all();
    int idx;
    idx = (m_n / PS) % ND;
    chk("code_out", int'(bus.code_out), exp_code(idx));
    chk("digit_sel", int'(bus.digit_sel), 1 << idx);
    chk("frame_done", int'(bus.frame_done), int'(m_fd));
    chk("pending", int'(bus.pending), int'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bus.load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic load_and_run(input logic [15:0] v, input int cycles);
    bus.digits_in = v;
    bus.load = 1'b1;
    run(cycles);
  endtask

  initial begin
    bus.digits_in = '0;
    bus.load = 1'b0;
    bus.blank_lz_en = 1'b0;
`ifdef BLINK_EN
    bus.blink_mask = '0;
`endif
    model_reset();
    #12;
    check_all();
    chk("reset_code", int'(bus.code_out), 14);
    chk("reset_sel", int'(bus.digit_sel), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(2 * FRAME + 1);
    load_and_run(16'h1234, 2 * FRAME);

    bus.blank_lz_en = 1'b1;
    load_and_run(16'h0050, 2 * FRAME + 2);
    load_and_run(16'h0000, 2 * FRAME + 1);
    load_and_run(16'h0C00, 2 * FRAME + 3);
    bus.blank_lz_en = 1'b0;

    // second load lands exactly on the commit edge
    load_and_run(16'hAAAA, 1);
    for (int k = 0; k < FRAME && ((m_n + 1) % FRAME) != 0; k++) step();
    load_and_run(16'h5678, 1);
    chk("coincident_pending", int'(bus.pending), 1);
    run(2 * FRAME + 1);

    // asynchronous reset in the middle of a slot with a value pending
    load_and_run(16'h9999, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midreset_pending", int'(bus.pending), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(2 * FRAME);

`ifdef BLINK_EN
    bus.blink_mask = 4'b0001;
    load_and_run(16'h1234, 6 * FRAME);
`endif

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.digits_in = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bus.digits_in[15:8] = 8'h00;
        if ($urandom_range(0, 2) == 0) bus.digits_in[15:4] = 12'h000;
        bus.load = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) bus.blank_lz_en = ~bus.blank_lz_en;
`ifdef BLINK_EN
      if ($urandom_range(0, 127) == 0) bus.blink_mask = 4'($urandom);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
